i2s_tdm_tx: RTL and testbench



---
 rtl/i2s_tdm_tx.sv | 166 ++++++++++++++++
 tb/tb_i2s_tdm_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx: serial audio transmitter, I2S (stereo, 50 % LRCLK) or TDM
// (N channels, one-bit frame-sync pulse), fed by a small frame FIFO.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   prescaler     SCLK half-period in clk cycles, 0 = stopped (latched per frame)
//   mode          0 = I2S, 1 = TDM (latched per frame)
//   s_valid       frame offered
//   s_ready       FIFO can accept a frame (registered)
//   s_data        frame, channel 0 in bits [SAMPLE_W-1:0]
//   sclk          bit clock
//   lrclk         word select (I2S) or frame sync (TDM)
//   sdata         serial data, MSB first, one bit period delayed
//   frame_start   one-clk pulse when a frame is loaded
//   underrun_cnt  saturating count of frames sent from an empty FIFO
module i2s_tdm_tx #(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 16,
  parameter int CHANNELS   = 2,
  parameter int PRESCALE_W = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PRESCALE_W-1:0]        prescaler,
  input  logic                         mode,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [CHANNELS*SAMPLE_W-1:0] s_data,
  output logic                         sclk,
  output logic                         lrclk,
  output logic                         sdata,
  output logic                         frame_start,
  output logic [15:0]                  underrun_cnt
);

  localparam int FRAME_W = CHANNELS * SAMPLE_W;
  localparam int N       = CHANNELS * SLOT_W;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int BW      = $clog2(N);
  localparam int CW      = PRESCALE_W + 1;

  typedef enum logic {IDLE, RUN} state_t;

  // ---------------------------------------------------------------- FIFO
  logic [FRAME_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count, count_next;
  logic               push, pop, empty;

  // ---------------------------------------------------------------- engine
  state_t              state;
  logic [PRESCALE_W-1:0] p_lat;
  logic                m_lat;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       two_p;
  logic [BW-1:0]       bit_idx;
  logic [N-1:0]        shreg;
  logic [N-1:0]        frame_img;
  logic                period_end, half, load, start;

  assign empty      = (count == '0);
  assign push       = s_valid && s_ready;
  assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);

  assign two_p      = {p_lat, 1'b0};
  assign period_end = (cnt == two_p - CW'(1));
  assign half       = (cnt == CW'(p_lat) - CW'(1));

  // A load is evaluated at every frame boundary; it only starts a frame when
  // the live prescaler is non-zero, otherwise the engine parks in IDLE.
  assign load  = (state == IDLE) ? (prescaler != '0)
                                 : (period_end && (bit_idx == BW'(N-1)));
  assign start = load && (prescaler != '0);
  assign pop   = start && !empty;

  // Head-of-FIFO frame laid out MSB-first: frame bit 0 sits in frame_img[N-1],
  // each slot left-justified with zero padding after the sample.
  // NOTE: a default assignment first keeps this block purely combinational.
  always_comb begin
    frame_img = '0;
    for (int c = 0; c < CHANNELS; c++)
      frame_img[N-1-c*SLOT_W -: SAMPLE_W] = mem[rd_ptr][c*SAMPLE_W +: SAMPLE_W];
  end

  // NOTE: sample storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      s_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count   <= count_next;
      s_ready <= (count_next != (AW+1)'(FIFO_DEPTH));
    end
  end

  // Serialiser. shreg shifts left once per bit period; after the last shift
  // its MSB still holds the final frame bit, which is what bit period 0 of
  // the next frame must drive (the one-bit delay).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      p_lat        <= '0;
      m_lat        <= 1'b0;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      sclk         <= 1'b0;
      lrclk        <= 1'b0;
      sdata        <= 1'b0;
      frame_start  <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      frame_start <= 1'b0;
      if (load) begin
        p_lat   <= prescaler;
        m_lat   <= mode;
        cnt     <= '0;
        bit_idx <= '0;
        sclk    <= 1'b0;
        if (!start) begin
          state <= IDLE;
          lrclk <= 1'b0;
          sdata <= 1'b0;
        end else begin
          state       <= RUN;
          frame_start <= 1'b1;
          // Bit period 0 carries the previous frame's last bit, which lies in
          // the upper half in I2S; in TDM this is the sync pulse.
          lrclk       <= 1'b1;
          sdata       <= shreg[N-1];
          if (!empty) begin
            shreg <= frame_img;
          end else begin
            shreg <= '0;
            if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
          end
        end
      end else if (state == RUN) begin
        if (period_end) begin
          cnt     <= '0;
          sclk    <= 1'b0;
          bit_idx <= bit_idx + BW'(1);
          sdata   <= shreg[N-1];
          shreg   <= {shreg[N-2:0], 1'b0};
          // New period drives frame bit bit_idx; upper half selects right channel.
          lrclk   <= m_lat ? 1'b0 : (bit_idx >= BW'(N/2));
        end else begin
          cnt <= cnt + CW'(1);
          if (half) sclk <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Self-checking bench for i2s_tdm_tx (4 channels, 24-bit samples in 32-bit
// slots). Accepted frames go into a scoreboard queue; a negedge monitor pops
// one per frame load and compares every clk of the serial waveform against a
// reference computed from the frame-layout rules.
module tb_i2s_tdm_tx;

  localparam int SW = 24;
  localparam int SL = 32;
  localparam int CH = 4;
  localparam int PW = 8;
  localparam int FD = 4;
  localparam int N  = CH * SL;
  localparam int FW = CH * SW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] prescaler = '0;
  logic          mode = 1'b0;
  logic          s_valid = 1'b0;
  logic [FW-1:0] s_data = '0;
  logic          s_ready, sclk, lrclk, sdata, frame_start;
  logic [15:0]   underrun_cnt;

  i2s_tdm_tx #(
    .SAMPLE_W(SW), .SLOT_W(SL), .CHANNELS(CH), .PRESCALE_W(PW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .prescaler(prescaler), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .sclk(sclk), .lrclk(lrclk), .sdata(sdata), .frame_start(frame_start),
    .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // ------------------------------------------------------------ scoreboard
  typedef struct {
    logic [FW-1:0] data;
    longint        stamp;   // clk edge on which the frame was accepted
  } entry_t;

  entry_t        exp_q[$];
  longint        cyc = 0;
  logic [PW-1:0] presc_q = '0;
  logic          mode_q = 1'b0;
  logic          rst_q = 1'b1;

  // Record accepted frames and the inputs present at each rising edge.
  always @(posedge clk) begin
    if (!rst && s_valid && s_ready) exp_q.push_back('{s_data, cyc});
    presc_q <= prescaler;
    mode_q  <= mode;
    rst_q   <= rst;
    cyc     <= cyc + 1;
  end

  // ------------------------------------------------------------ reference
  logic        in_frame = 1'b0;
  int          k = 0;
  int          cur_p = 0;
  logic        cur_m = 1'b0;
  logic        bits [N];
  logic        first_bit = 1'b0;
  logic        prev_last = 1'b0;
  logic [15:0] exp_und = '0;
  int          frames_seen = 0;
  logic        e_fs, e_sclk, e_lr, e_sd;
  int          b, ph;

  // Frame loaded on the edge just before this negedge (edge number cyc-1);
  // only frames accepted on an earlier edge can be popped by it.
  task automatic start_frame();
    logic [FW-1:0] d;
    entry_t        e;
    cur_p = int'(presc_q);
    cur_m = mode_q;
    k = 0;
    in_frame = 1'b1;
    frames_seen++;
    first_bit = prev_last;
    if (exp_q.size() > 0 && exp_q[0].stamp < cyc - 1) begin
      e = exp_q.pop_front();
      d = e.data;
    end else begin
      d = '0;
      if (exp_und != 16'hFFFF) exp_und = exp_und + 16'd1;
    end
    for (int i = 0; i < N; i++) begin
      int c   = i / SL;
      int pos = i % SL;
      bits[i] = (pos < SW) ? d[c*SW + SW-1-pos] : 1'b0;
    end
    prev_last = bits[N-1];
  endtask

  always @(negedge clk) begin
    if (rst) begin
      in_frame  = 1'b0;
      exp_q.delete();
      prev_last = 1'b0;
      exp_und   = '0;
      check("reset_outputs",
            64'({frame_start, sclk, lrclk, sdata, s_ready, underrun_cnt}),
            64'({5'b00001, 16'h0000}));
    end else begin
      if (in_frame && k == 2*cur_p*N) in_frame = 1'b0;
      if (!in_frame && presc_q != '0 && !rst_q) start_frame();
      if (in_frame) begin
        b      = k / (2*cur_p);
        ph     = k % (2*cur_p);
        e_fs   = (k == 0);
        e_sclk = (ph >= cur_p);
        e_sd   = (b == 0) ? first_bit : bits[b-1];
        e_lr   = cur_m ? (b == 0) : (((b + N - 1) % N) >= N/2);
        k++;
        check("frame_cycle",
              64'({frame_start, sclk, lrclk, sdata, s_ready, underrun_cnt}),
              64'({e_fs, e_sclk, e_lr, e_sd, exp_q.size() < FD, exp_und}));
      end else begin
        check("idle_cycle",
              64'({frame_start, sclk, lrclk, sdata, s_ready, underrun_cnt}),
              64'({4'b0000, exp_q.size() < FD, exp_und}));
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one frame until accepted, bounded by a cycle budget.
  task automatic push_frame(input logic [FW-1:0] d);
    logic ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int t = 0; t < 5000 && !ok; t++) begin
      ok = s_ready;
      tick(1);
    end
    s_valid = 1'b0;
    check("push_accepted", 64'(ok), 64'(1));
  endtask

  function automatic logic [FW-1:0] rand_frame();
    return FW'({$urandom, $urandom, $urandom});
  endfunction

  initial begin
    logic ok;
    tick(3);
    rst = 1'b0;
    tick(4);

    // I2S: two frames queued while stopped, then start at P=2.
    push_frame({24'h000000, 24'h000000, 24'h123456, 24'hABCDEF});
    push_frame(rand_frame());
    prescaler = 8'd2;
    mode      = 1'b0;
    tick(2*2*N + 50);

    // TDM at P=1, taken over from the next load onward.
    push_frame({24'h123456, 24'h000000, 24'h7FFFFF, 24'h800001});
    mode      = 1'b1;
    prescaler = 8'd1;
    tick(2*2*N + 2*N);

    // Randomised traffic with mid-frame parameter changes.
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 9) < 6) push_frame(rand_frame());
      if ($urandom_range(0, 9) < 2) begin
        prescaler = PW'($urandom_range(1, 3));
        mode      = 1'($urandom_range(0, 1));
      end
      tick($urandom_range(0, 300));
    end

    // Backpressure: s_valid held with incrementing data over 10 frames.
    prescaler = 8'd4;
    mode      = 1'b0;
    s_valid   = 1'b1;
    s_data    = FW'(96'h100);
    repeat (10*8*N) begin
      ok = s_ready;
      tick(1);
      if (ok) s_data = s_data + FW'(1);
    end
    s_valid = 1'b0;

    // Underrun: FIFO drains, empty frames are counted, then one push.
    prescaler = 8'd1;
    tick(8*N + 3000);
    push_frame(rand_frame());
    tick(6*N);

    // Stop mid-frame: current frame finishes, then IDLE.
    tick(N/2);
    prescaler = 8'd0;
    tick(4*N);

    // Restart, queue 3 frames, reset around bit period 10.
    prescaler = 8'd2;
    mode      = 1'b0;
    push_frame(rand_frame());
    push_frame(rand_frame());
    push_frame(rand_frame());
    tick(40);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2*2*N + 20);

    check("frames_seen_min", 64'(frames_seen >= 20), 64'(1));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
